// File: rtl/fft_inplace_engine_if.sv
// Bus between the in-place FFT engine and the block that owns the sample memory.
// The engine takes the slave modport and the memory/controller side takes the master modport.
interface fft_inplace_engine_if #(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 10
);
   logic                     start;
   logic                     ack;
   logic                     done;
   logic [3:0]               state;
   logic signed [DATA_W-1:0] x_top_re;
   logic signed [DATA_W-1:0] x_top_im;
   logic signed [DATA_W-1:0] x_bot_re;
   logic signed [DATA_W-1:0] x_bot_im;
   logic signed [DATA_W-1:0] y_top_re;
   logic signed [DATA_W-1:0] y_top_im;
   logic signed [DATA_W-1:0] y_bot_re;
   logic signed [DATA_W-1:0] y_bot_im;
   logic [IDX_W-1:0]         i_top;
   logic [IDX_W-1:0]         i_bot;
   logic [IDX_W-1:0]         address;

   modport master (
      output start, ack, x_top_re, x_top_im, x_bot_re, x_bot_im,
      input  done, state, y_top_re, y_top_im, y_bot_re, y_bot_im,
             i_top, i_bot, address
   );

   modport slave (
      input  start, ack, x_top_re, x_top_im, x_bot_re, x_bot_im,
      output done, state, y_top_re, y_top_im, y_bot_re, y_bot_im,
             i_top, i_bot, address
   );
endinterface

// File: rtl/fft_inplace_engine.sv
// In-place radix-2 DIT FFT: pointer sequencer, twiddle ROM and combinational butterfly.
// Define FFT_STAGE_SCALE_EN to halve every butterfly output (whole transform scaled by 1/N).
module fft_inplace_engine #(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 10,
   parameter int LOG2N  = 8,
   parameter int TW_W   = 16
) (
   input logic                clk,
   input logic                rst_n,
   fft_inplace_engine_if.slave bus
);
   localparam int  N  = 1 << LOG2N;
   localparam int  CW = IDX_W + 2;
   localparam int  PW = DATA_W + TW_W + 1;
   localparam real PI = 3.14159265358979323846;

   typedef enum logic [3:0] {
      INIT = 4'd0,
      DONE = 4'd1,
      PROC = 4'd2
   } state_t;

   state_t           state;
   logic [3:0]       stage;
   logic [3:0]       nxt_stage;
   logic [CW-1:0]    grp;
   logic [CW-1:0]    k;
   logic [CW-1:0]    span;
   logic [CW-1:0]    nxt_grp;
   logic [CW-1:0]    nxt_k;
   logic [CW-1:0]    nxt_span;
   logic             last_k;
   logic             last_g;
   logic             last_s;
   logic             last_bfly;
   logic             done;
   logic [IDX_W-1:0] i_top;
   logic [IDX_W-1:0] i_bot;
   logic [IDX_W-1:0] address;
   logic [IDX_W-1:0] nxt_top;
   logic [IDX_W-1:0] nxt_bot;
   logic [IDX_W-1:0] nxt_addr;

   // Loop nest k (inner), group, stage; pointers for the following butterfly are precomputed here.
   always_comb begin
      span      = CW'(1) << stage;
      last_k    = (k == span - CW'(1));
      last_g    = ((grp + (span << 1)) == CW'(N));
      last_s    = (stage == 4'(LOG2N - 1));
      last_bfly = last_k && last_g && last_s;
      nxt_stage = stage;
      nxt_grp   = grp;
      nxt_k     = k + CW'(1);
      if (last_k) begin
         nxt_k = '0;
         if (last_g) begin
            nxt_grp   = '0;
            nxt_stage = stage + 4'd1;
         end else begin
            nxt_grp = grp + (span << 1);
         end
      end
      nxt_span = CW'(1) << nxt_stage;
      nxt_top  = IDX_W'(nxt_grp + nxt_k);
      nxt_bot  = IDX_W'(nxt_grp + nxt_k + nxt_span);
      nxt_addr = IDX_W'(nxt_k << (4'd9 - nxt_stage));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= INIT;
         stage   <= '0;
         grp     <= '0;
         k       <= '0;
         done    <= 1'b0;
         i_top   <= '0;
         i_bot   <= '0;
         address <= '0;
      end else begin
         case (state)
            INIT: begin
               if (bus.start) begin
                  state   <= PROC;
                  stage   <= '0;
                  grp     <= '0;
                  k       <= '0;
                  i_top   <= '0;
                  i_bot   <= IDX_W'(1);
                  address <= '0;
               end
            end
            PROC: begin
               if (last_bfly) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  stage   <= '0;
                  grp     <= '0;
                  k       <= '0;
                  i_top   <= '0;
                  i_bot   <= '0;
                  address <= '0;
               end else begin
                  stage   <= nxt_stage;
                  grp     <= nxt_grp;
                  k       <= nxt_k;
                  i_top   <= nxt_top;
                  i_bot   <= nxt_bot;
                  address <= nxt_addr;
               end
            end
            DONE: begin
               if (bus.ack) begin
                  state <= INIT;
                  done  <= 1'b0;
               end
            end
            default: begin
               state <= INIT;
               done  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.state   = state;
   assign bus.done    = done;
   assign bus.i_top   = i_top;
   assign bus.i_bot   = i_bot;
   assign bus.address = address;

   // Half-circle table W(a) = cos - j*sin, Q2.14, rounded half away from zero at elaboration.
   logic signed [TW_W-1:0] rom_re [512];
   logic signed [TW_W-1:0] rom_im [512];

   for (genvar a = 0; a < 512; a++) begin : g_rom
      localparam real ANG = 2.0 * PI * a / 1024.0;
      localparam real CR  = $cos(ANG) * 16384.0;
      localparam real CI  = -$sin(ANG) * 16384.0;
      localparam int  QR  = (CR >= 0.0) ? $rtoi(CR + 0.5) : -$rtoi(0.5 - CR);
      localparam int  QI  = (CI >= 0.0) ? $rtoi(CI + 0.5) : -$rtoi(0.5 - CI);
      assign rom_re[a] = TW_W'(QR);
      assign rom_im[a] = TW_W'(QI);
   end

   logic signed [TW_W-1:0] w_re;
   logic signed [TW_W-1:0] w_im;
   logic signed [PW-1:0]   xt_re;
   logic signed [PW-1:0]   xt_im;
   logic signed [PW-1:0]   xb_re;
   logic signed [PW-1:0]   xb_im;
   logic signed [PW-1:0]   wr_x;
   logic signed [PW-1:0]   wi_x;
   logic signed [PW-1:0]   p_re;
   logic signed [PW-1:0]   p_im;
   logic signed [PW-1:0]   yt_re;
   logic signed [PW-1:0]   yt_im;
   logic signed [PW-1:0]   yb_re;
   logic signed [PW-1:0]   yb_im;

   // Full-precision products and sums; results wrap to DATA_W with no saturation.
   always_comb begin
      w_re  = rom_re[address[8:0]];
      w_im  = rom_im[address[8:0]];
      xt_re = PW'(bus.x_top_re);
      xt_im = PW'(bus.x_top_im);
      xb_re = PW'(bus.x_bot_re);
      xb_im = PW'(bus.x_bot_im);
      wr_x  = PW'(w_re);
      wi_x  = PW'(w_im);
      p_re  = (xb_re * wr_x - xb_im * wi_x) >>> 14;
      p_im  = (xb_re * wi_x + xb_im * wr_x) >>> 14;
      yt_re = xt_re + p_re;
      yt_im = xt_im + p_im;
      yb_re = xt_re - p_re;
      yb_im = xt_im - p_im;
`ifdef FFT_STAGE_SCALE_EN
      yt_re = yt_re >>> 1;
      yt_im = yt_im >>> 1;
      yb_re = yb_re >>> 1;
      yb_im = yb_im >>> 1;
`else
      yt_re = yt_re;
      yt_im = yt_im;
      yb_re = yb_re;
      yb_im = yb_im;
`endif
   end

   assign bus.y_top_re = yt_re[DATA_W-1:0];
   assign bus.y_top_im = yt_im[DATA_W-1:0];
   assign bus.y_bot_re = yb_re[DATA_W-1:0];
   assign bus.y_bot_im = yb_im[DATA_W-1:0];

   logic unused_bits;
   assign unused_bits = ^{yt_re[PW-1:DATA_W], yt_im[PW-1:DATA_W],
                          yb_re[PW-1:DATA_W], yb_im[PW-1:DATA_W]};
endmodule

// File: tb/tb_fft_inplace_engine.sv
// Self-checking bench for fft_inplace_engine: pointer sequence, butterfly math, handshakes, full transforms.
module tb_fft_inplace_engine;
   localparam int  DATA_W = 32;
   localparam int  IDX_W  = 10;
   localparam int  LOG2N  = 8;
   localparam int  TW_W   = 16;
   localparam int  N      = 1 << LOG2N;
   localparam int  NBF    = LOG2N * N / 2;
   localparam real PI     = 3.14159265358979323846;
`ifdef FFT_STAGE_SCALE_EN
   localparam int  SC     = 1;
`else
   localparam int  SC     = 0;
`endif

   typedef struct {
      logic signed [31:0] tr;
      logic signed [31:0] ti;
      logic signed [31:0] br;
      logic signed [31:0] bi;
   } bfly_t;

   typedef struct {
      logic signed [31:0] re;
      logic signed [31:0] im;
   } bin_t;

   logic clk;
   logic rst_n;

   fft_inplace_engine_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

   fft_inplace_engine #(
      .DATA_W(DATA_W),
      .IDX_W (IDX_W),
      .LOG2N (LOG2N),
      .TW_W  (TW_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int                 testsRun;
   int                 failCount;
   logic               directMode;
   logic               loadReq;
   int                 loadPattern;
   logic signed [31:0] memRe [N];
   logic signed [31:0] memIm [N];
   logic signed [31:0] dirTopRe;
   logic signed [31:0] dirTopIm;
   logic signed [31:0] dirBotRe;
   logic signed [31:0] dirBotIm;
   logic [29:0]        ptrQ [$];
   bfly_t              bflyQ [$];
   bin_t               binQ [$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Sample memory model: engine reads combinationally and writes back on the PROC clock edge.
   assign bus.x_top_re = directMode ? dirTopRe : memRe[bus.i_top[7:0]];
   assign bus.x_top_im = directMode ? dirTopIm : memIm[bus.i_top[7:0]];
   assign bus.x_bot_re = directMode ? dirBotRe : memRe[bus.i_bot[7:0]];
   assign bus.x_bot_im = directMode ? dirBotIm : memIm[bus.i_bot[7:0]];

   always @(posedge clk) begin
      if (loadReq) begin
         for (int i = 0; i < N; i++) begin
            memRe[i] <= (loadPattern == 0) ? 32'sd1000 : ((i == 0) ? 32'sd4096 : 32'sd0);
            memIm[i] <= 32'sd0;
         end
      end else if (!directMode && bus.state == 4'd2) begin
         memRe[bus.i_top[7:0]] <= bus.y_top_re;
         memIm[bus.i_top[7:0]] <= bus.y_top_im;
         memRe[bus.i_bot[7:0]] <= bus.y_bot_re;
         memIm[bus.i_bot[7:0]] <= bus.y_bot_im;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   function automatic logic [29:0] modelPtr(input int t);
      int s;
      int j;
      int span;
      int g;
      int k;
      s    = t / (N / 2);
      j    = t % (N / 2);
      span = 1 << s;
      g    = (j / span) * 2 * span;
      k    = j % span;
      return {10'(g + k), 10'(g + k + span), 10'(k * (1024 >> (s + 1)))};
   endfunction

   function automatic int roundQ14(input real v);
      real s;
      s = v * 16384.0;
      if (s >= 0.0) return $rtoi(s + 0.5);
      return -$rtoi(0.5 - s);
   endfunction

   // Loads a memory pattern (0: all 1000+0j, 1: impulse 4096 at index 0) and queues the expected spectrum.
   task automatic applyStimulus(input int pattern);
      bin_t b;
      @(negedge clk);
      loadPattern = pattern;
      loadReq     = 1'b1;
      @(negedge clk);
      loadReq = 1'b0;
      binQ.delete();
      for (int i = 0; i < N; i++) begin
         if (pattern == 0) b.re = (i == 0) ? (256000 >>> (SC * LOG2N)) : 0;
         else              b.re = 4096 >>> (SC * LOG2N);
         b.im = 0;
         binQ.push_back(b);
      end
   endtask

   task automatic checkBins(input string tag);
      bin_t b;
      for (int i = 0; i < N; i++) begin
         if (binQ.size() == 0) begin
            checkOutput({tag, "_underflow"}, 64'(i), 64'(N));
            break;
         end
         b = binQ.pop_front();
         checkOutput({tag, "_re"}, memRe[i], b.re);
         checkOutput({tag, "_im"}, memIm[i], b.im);
      end
   endtask

   task automatic spotCheck(input int pc);
      case (pc)
         1:    checkOutput("ptr_c1",    {bus.i_top, bus.i_bot, bus.address}, {10'd0,   10'd1,   10'd0});
         2:    checkOutput("ptr_c2",    {bus.i_top, bus.i_bot, bus.address}, {10'd2,   10'd3,   10'd0});
         129:  checkOutput("ptr_c129",  {bus.i_top, bus.i_bot, bus.address}, {10'd0,   10'd2,   10'd0});
         130:  checkOutput("ptr_c130",  {bus.i_top, bus.i_bot, bus.address}, {10'd1,   10'd3,   10'd256});
         1024: checkOutput("ptr_c1024", {bus.i_top, bus.i_bot, bus.address}, {10'd127, 10'd255, 10'd508});
         default: ;
      endcase
   endtask

   // Drives one butterfly directly, queues the modelled result and compares it just before the next edge.
   task automatic driveBfly(input int pc, input logic [9:0] addr);
      int     tr, ti, br, bi, wr, wi;
      longint pr, pim, ytr, yti, ybr, ybi;
      bfly_t  e;
      if (pc == 1) begin
         tr = 100; ti = 0; br = 50; bi = 0;
      end else if (pc == 130) begin
         tr = 0; ti = 0; br = 1000; bi = 0;
      end else begin
         tr = $urandom; ti = $urandom; br = $urandom; bi = $urandom;
      end
      dirTopRe = tr;
      dirTopIm = ti;
      dirBotRe = br;
      dirBotIm = bi;
      wr  = roundQ14($cos(2.0 * PI * real'(int'(addr)) / 1024.0));
      wi  = roundQ14(-$sin(2.0 * PI * real'(int'(addr)) / 1024.0));
      pr  = (longint'(br) * wr - longint'(bi) * wi) >>> 14;
      pim = (longint'(br) * wi + longint'(bi) * wr) >>> 14;
      ytr = (longint'(tr) + pr) >>> SC;
      yti = (longint'(ti) + pim) >>> SC;
      ybr = (longint'(tr) - pr) >>> SC;
      ybi = (longint'(ti) - pim) >>> SC;
      e.tr = ytr[31:0];
      e.ti = yti[31:0];
      e.br = ybr[31:0];
      e.bi = ybi[31:0];
      bflyQ.push_back(e);
      #1;
      e = bflyQ.pop_front();
      checkOutput("y_top_re", bus.y_top_re, e.tr);
      checkOutput("y_top_im", bus.y_top_im, e.ti);
      checkOutput("y_bot_re", bus.y_bot_re, e.br);
      checkOutput("y_bot_im", bus.y_bot_im, e.bi);
      if (pc == 1) begin
         checkOutput("bf_a0_top_re", bus.y_top_re, 150 >>> SC);
         checkOutput("bf_a0_top_im", bus.y_top_im, 0);
         checkOutput("bf_a0_bot_re", bus.y_bot_re, 50 >>> SC);
         checkOutput("bf_a0_bot_im", bus.y_bot_im, 0);
      end else if (pc == 130) begin
         checkOutput("bf_a256_top_re", bus.y_top_re, 0);
         checkOutput("bf_a256_top_im", bus.y_top_im, -1000 >>> SC);
         checkOutput("bf_a256_bot_re", bus.y_bot_re, 0);
         checkOutput("bf_a256_bot_im", bus.y_bot_im, 1000 >>> SC);
      end
   endtask

   // Starts a transform with Start held for holdCycles edges; stops early after abortAt PROC cycles if nonzero.
   task automatic runTransform(input int holdCycles, input int abortAt, output int procCycles);
      logic [29:0] expPtr;
      procCycles = 0;
      ptrQ.delete();
      for (int t = 0; t < NBF; t++) ptrQ.push_back(modelPtr(t));
      @(negedge clk);
      bus.start = 1'b1;
      for (int cyc = 1; cyc <= NBF + 64; cyc++) begin
         @(negedge clk);
         if (cyc == holdCycles) bus.start = 1'b0;
         if (bus.state == 4'd2) begin
            procCycles++;
            if (ptrQ.size() == 0) begin
               checkOutput("ptr_overrun", 64'(procCycles), 64'(NBF));
               break;
            end
            expPtr = ptrQ.pop_front();
            checkOutput("ptr_seq", {bus.i_top, bus.i_bot, bus.address}, 64'(expPtr));
            checkOutput("done_in_proc", 64'(bus.done), 64'd0);
            spotCheck(procCycles);
            if (directMode) driveBfly(procCycles, expPtr[9:0]);
            if (procCycles == abortAt) break;
         end else if (procCycles > 0) begin
            break;
         end
      end
      bus.start = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete, failed=%0d", failCount);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int pc;
      testsRun    = 0;
      failCount   = 0;
      rst_n       = 1'b0;
      bus.start   = 1'b0;
      bus.ack     = 1'b0;
      directMode  = 1'b0;
      loadReq     = 1'b0;
      loadPattern = 0;
      dirTopRe    = '0;
      dirTopIm    = '0;
      dirBotRe    = '0;
      dirBotIm    = '0;
      #12;
      checkOutput("rst_state", 64'(bus.state), 64'd0);
      checkOutput("rst_done", 64'(bus.done), 64'd0);
      checkOutput("rst_ptrs", {bus.i_top, bus.i_bot, bus.address}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] constant-input transform, Start held 3 cycles");
      applyStimulus(0);
      runTransform(3, 0, pc);
      checkOutput("proc_cycles_const", 64'(pc), 64'(NBF));
      checkOutput("done_state_const", 64'(bus.state), 64'd1);
      checkOutput("done_flag_const", 64'(bus.done), 64'd1);
      checkBins("bin_const");

      repeat (10) begin
         @(negedge clk);
         checkOutput("done_hold_state", 64'(bus.state), 64'd1);
         checkOutput("done_hold_flag", 64'(bus.done), 64'd1);
         checkOutput("done_hold_ptrs", {bus.i_top, bus.i_bot, bus.address}, 64'd0);
      end
      bus.ack = 1'b1;
      @(negedge clk);
      checkOutput("ack_state", 64'(bus.state), 64'd0);
      checkOutput("ack_done", 64'(bus.done), 64'd0);
      repeat (3) begin
         @(negedge clk);
         checkOutput("ack_hold_state", 64'(bus.state), 64'd0);
      end
      bus.ack = 1'b0;

      $display("[TB] impulse transform with Ack already high");
      applyStimulus(1);
      bus.ack = 1'b1;
      runTransform(1, 0, pc);
      checkOutput("proc_cycles_imp", 64'(pc), 64'(NBF));
      checkOutput("done_state_imp", 64'(bus.state), 64'd1);
      checkOutput("done_flag_imp", 64'(bus.done), 64'd1);
      @(negedge clk);
      checkOutput("early_ack_state", 64'(bus.state), 64'd0);
      checkOutput("early_ack_done", 64'(bus.done), 64'd0);
      bus.ack = 1'b0;
      checkBins("bin_imp");

      $display("[TB] direct butterfly run with reset at cycle 300");
      directMode = 1'b1;
      runTransform(1, 300, pc);
      checkOutput("abort_cycles", 64'(pc), 64'd300);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_state", 64'(bus.state), 64'd0);
      checkOutput("midrst_done", 64'(bus.done), 64'd0);
      checkOutput("midrst_ptrs", {bus.i_top, bus.i_bot, bus.address}, 64'd0);
      #1;
      rst_n = 1'b1;
      runTransform(1, 0, pc);
      checkOutput("proc_cycles_restart", 64'(pc), 64'(NBF));
      checkOutput("done_state_restart", 64'(bus.state), 64'd1);
      bus.ack = 1'b1;
      @(negedge clk);
      checkOutput("final_ack_state", 64'(bus.state), 64'd0);
      bus.ack = 1'b0;

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end
endmodule

// File: doc/fft_inplace_engine.md
Name: fft_inplace_engine

Overview:
- In-place radix-2 decimation-in-time FFT engine: a pointer/sequencing FSM plus a combinational butterfly with an internal twiddle ROM.
- Sample memory is external. Each processing cycle the engine emits two indices and a twiddle address, reads x_top/x_bot, and returns y_top/y_bot for write-back on the same clock edge.
- Input is in bit-reversed order; output is in natural order.

Parameters:
- DATA_W, 32, signed width of the real/imag sample parts.
- IDX_W, 10, width of i_top, i_bot and address (max 1024 points).
- LOG2N, 8, log2 of the transform length N (default 256); must be ≤ IDX_W.
- TW_W, 16, signed twiddle width, Q2.14 format (+1.0 = 16384).

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  begin a transform; sampled only in INIT.
- Ack  in  1  acknowledge completion; sampled only in DONE.
- x_top_re, x_top_im  in  DATA_W  signed sample at i_top.
- x_bot_re, x_bot_im  in  DATA_W  signed sample at i_bot.
- y_top_re, y_top_im  out  DATA_W  butterfly top result.
- y_bot_re, y_bot_im  out  DATA_W  butterfly bottom result.
- i_top, i_bot  out  IDX_W  memory indices of the current butterfly.
- address  out  IDX_W  twiddle ROM address (1024-point table basis).
- Done  out  1  high while in DONE.
- state  out  4  FSM state: 0 INIT, 1 DONE, 2 PROC.

Behaviour:
- Reset low (async): state=INIT; stage, group and k counters = 0; Done=0; i_top=i_bot=address=0.
- INIT → PROC on a clock edge with Start=1, counters cleared. Start is ignored in PROC and DONE.
- PROC performs one butterfly per cycle. For stage s (0..LOG2N-1), span = 2^s:
  - groups g step by 2^(s+1) from 0 to N-1; k runs 0..span-1;
  - i_top = g+k; i_bot = g+k+span;
  - address = k·(1024 >> (s+1)).
- Loop order: k innermost, then g, then s.
- Total PROC duration = LOG2N·N/2 cycles (1024 for N=256).
- After the last butterfly: PROC → DONE, and Done=1 from that edge.
- DONE → INIT on an edge with Ack=1; Done deasserts. If Ack is already high on DONE entry, DONE lasts exactly one cycle.
- In INIT and DONE: i_top, i_bot and address drive 0.
- Pointers, address, state and Done are registered/state-decoded.
- Butterfly is purely combinational, zero latency; y_* are valid in the same cycle as x_*.
- Twiddle: W = cos(2πa/1024) − j·sin(2πa/1024), for a = address, 0..511, in Q2.14, rounded to nearest.
  - Values are exact at a=0 (16384, 0) and a=256 (0, −16384).
  - Addresses ≥512 are never generated; if presented, the ROM returns W(a mod 512).
- Products: DATA_W × TW_W full width.
  - P_re = (xb_re·w_re − xb_im·w_im) >>> 14; P_im = (xb_re·w_im + xb_im·w_re) >>> 14.
  - Shift is arithmetic (floor).
  - y_top = x_top + P; y_bot = x_top − P, each truncated to DATA_W with no saturation.
- No internal scaling by default; the caller sizes inputs to avoid overflow.
- A write conflict cannot occur: i_top ≠ i_bot always, and every index pair is distinct within a stage.

Optional Feature:
- FFT_STAGE_SCALE_EN defined: every y output is additionally arithmetic-shifted right by 1 (per-stage ÷2). A full transform is then scaled by 1/N.
- Undefined: no scaling (as above).

Test Plan:
- Reset low mid-PROC (cycle 300) → immediately state=0, Done=0, i_top=i_bot=address=0; the next Start restarts from i_top=0, i_bot=1.
- Start=1 held 3 cycles → PROC for exactly 1024 cycles (held Start ignored):
  - cycles 1–2: (i_top, i_bot, address) = (0,1,0), (2,3,0);
  - cycle 129: (0,2,0); cycle 130: (1,3,256);
  - cycle 1024: (127,255,508);
  - then state=1, Done=1.
- Butterfly at address=0, x_top=100+0j, x_bot=50+0j → y_top=150+0j, y_bot=50+0j. At address=256, x_top=0, x_bot=1000+0j → y_top=0−1000j, y_bot=0+1000j.
- Full 256-point run with all inputs 1000+0j → X[0]=256000+0j, X[1..255]=0 exactly. With FFT_STAGE_SCALE_EN → X[0]=1000.
- Single impulse X_Re[0]=4096 (bit-reversed index 0) → every bin = 4096+0j (±1 LSB).
- DONE with Ack=0 for 10 cycles → Done stays 1, pointers 0. Ack=1 → INIT next edge, Done=0. Ack held high with Start=0 → stays INIT.
